// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle joining the fetch stage, load/store path, arbiter and unified memory.
// master is the arbiter's view; slave is the requesters' and memory's view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              d_req;
   logic              d_we;
   logic [2:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic              m_req;
   logic              m_we;
   logic [2:0]        m_size;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   logic              busy;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
      output if_ready, if_rvalid, if_rdata, if_err,
      output d_ready, d_rvalid, d_rdata, d_err,
      output m_req, m_we, m_size, m_addr, m_wdata, busy
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
      input  if_ready, if_rvalid, if_rdata, if_err,
      input  d_ready, d_rvalid, d_rdata, d_err,
      input  m_req, m_we, m_size, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and load/store, alternating on ties.
// Define MEM_ARB_TIMEOUT_EN to add an ack watchdog that completes a stalled access with an error.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 255
`endif
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   typedef enum logic {StIdle, StIssue} state_t;

   localparam logic OwnFetch = 1'b0;
   localparam logic OwnData  = 1'b1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [2:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_err_q, if_err_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_err_q, d_err_d;
   logic              grant_if, grant_d;
   logic              timeout_hit;
   logic [DATA_W-1:0] rdata_v;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CntRaw = $clog2(TIMEOUT + 1);
   localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Held at zero in IDLE so every ISSUE starts from a clean count.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (!bus.m_ack) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the ISSUE cycle whose increment would reach the limit; an ack wins.
   assign timeout_hit = (state_q == StIssue) && !bus.m_ack && (cnt_q == CntW'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      if_rvalid_d  = 1'b0;
      if_rdata_d   = if_rdata_q;
      if_err_d     = if_err_q;
      d_rvalid_d   = 1'b0;
      d_rdata_d    = d_rdata_q;
      d_err_d      = d_err_q;
      grant_if     = 1'b0;
      grant_d      = 1'b0;
      rdata_v      = bus.m_rdata;

      unique case (state_q)
         StIdle: begin
            // rst gates the combinational readies so they drop without a clock edge.
            if (!rst) begin
               if (bus.d_req && (!bus.if_req || last_grant_q == OwnFetch)) begin
                  grant_d = 1'b1;
               end else if (bus.if_req) begin
                  grant_if = 1'b1;
               end
            end
            if (grant_d) begin
               state_d      = StIssue;
               owner_d      = OwnData;
               last_grant_d = OwnData;
               we_d         = bus.d_we;
               size_d       = bus.d_size;
               addr_d       = bus.d_addr;
               wdata_d      = bus.d_wdata;
            end else if (grant_if) begin
               state_d      = StIssue;
               owner_d      = OwnFetch;
               last_grant_d = OwnFetch;
               we_d         = 1'b0;
               size_d       = 3'b010;
               addr_d       = bus.if_addr;
               wdata_d      = '0;
            end
         end
         StIssue: begin
            if (bus.m_ack || timeout_hit) begin
               state_d = StIdle;
               if (timeout_hit || we_q) begin
                  rdata_v = '0;
               end
               if (owner_q == OwnFetch) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = rdata_v;
                  if_err_d    = timeout_hit;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = rdata_v;
                  d_err_d    = timeout_hit;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= OwnFetch;
         last_grant_q <= OwnFetch;
         we_q         <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         if_rvalid_q  <= 1'b0;
         if_rdata_q   <= '0;
         if_err_q     <= 1'b0;
         d_rvalid_q   <= 1'b0;
         d_rdata_q    <= '0;
         d_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         if_rvalid_q  <= if_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         if_err_q     <= if_err_d;
         d_rvalid_q   <= d_rvalid_d;
         d_rdata_q    <= d_rdata_d;
         d_err_q      <= d_err_d;
      end
   end

   assign bus.if_ready  = grant_if;
   assign bus.d_ready   = grant_d;
   assign bus.m_req     = (state_q == StIssue);
   assign bus.busy      = (state_q == StIssue);
   assign bus.m_we      = we_q;
   assign bus.m_size    = size_q;
   assign bus.m_addr    = addr_q;
   assign bus.m_wdata   = wdata_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_err    = if_err_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus reset, contention and
// watchdog sequences. Expectations follow MEM_ARB_TIMEOUT_EN (TIMEOUT=4 when defined).
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      .TIMEOUT(4)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [2:0]  d_size;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        m_ack;
      logic [31:0] m_rdata;
   } in_t;

   typedef struct packed {
      logic        if_ready;
      logic        d_ready;
      logic        m_req;
      logic        busy;
      logic        m_we;
      logic [2:0]  m_size;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic        if_rvalid;
      logic        if_err;
      logic [31:0] if_rdata;
      logic        d_rvalid;
      logic        d_err;
      logic [31:0] d_rdata;
   } out_t;

   typedef struct {
      in_t  stim;
      out_t exp;
   } vec_t;

   vec_t tbl[$];

   logic [3:0] cont_exp [8] = '{4'b0100, 4'b0000, 4'b1001, 4'b0000,
                                4'b0110, 4'b0000, 4'b1001, 4'b0000};

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t s);
      bus.if_req  = s.if_req;
      bus.if_addr = s.if_addr;
      bus.d_req   = s.d_req;
      bus.d_we    = s.d_we;
      bus.d_size  = s.d_size;
      bus.d_addr  = s.d_addr;
      bus.d_wdata = s.d_wdata;
      bus.m_ack   = s.m_ack;
      bus.m_rdata = s.m_rdata;
   endtask

   function automatic out_t sample();
      out_t o;
      o.if_ready  = bus.if_ready;
      o.d_ready   = bus.d_ready;
      o.m_req     = bus.m_req;
      o.busy      = bus.busy;
      o.m_we      = bus.m_we;
      o.m_size    = bus.m_size;
      o.m_addr    = bus.m_addr;
      o.m_wdata   = bus.m_wdata;
      o.if_rvalid = bus.if_rvalid;
      o.if_err    = bus.if_err;
      o.if_rdata  = bus.if_rdata;
      o.d_rvalid  = bus.d_rvalid;
      o.d_err     = bus.d_err;
      o.d_rdata   = bus.d_rdata;
      return o;
   endfunction

   task automatic add(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
                      input logic [2:0] dsz, input logic [31:0] da, input logic [31:0] dwd,
                      input logic ack, input logic [31:0] rd,
                      input logic e_ifr, input logic e_dr, input logic e_mreq, input logic e_mwe,
                      input logic [2:0] e_msz, input logic [31:0] e_ma, input logic [31:0] e_mwd,
                      input logic e_ifrv, input logic [31:0] e_ifrd,
                      input logic e_drv, input logic [31:0] e_drd);
      vec_t v;
      v.stim = '{ifr, ifa, dr, dwe, dsz, da, dwd, ack, rd};
      v.exp  = '{e_ifr, e_dr, e_mreq, e_mreq, e_mwe, e_msz, e_ma, e_mwd,
                 e_ifrv, 1'b0, e_ifrd, e_drv, 1'b0, e_drd};
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int   cnt;
      logic stop;

      // idle / ack-in-IDLE ignored
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,0,0,0,     0,0,          0,0);
      add(0,0,     0,0,0,0,0,     1,32'hDEAD,   0,0,0, 0,0,0,0,     0,0,          0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,0,0,0,     0,0,          0,0);
      // single fetch, ack in cycle 1
      add(1,'h100, 0,0,0,0,0,     0,0,          1,0,0, 0,0,0,0,     0,0,          0,0);
      add(0,0,     0,0,0,0,0,     1,'h00500093, 0,0,1, 0,2,'h100,0, 0,0,          0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,2,'h100,0, 1,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,2,'h100,0, 0,'h00500093, 0,0);
      // store, ack delayed to cycle 4
      add(0,0,     1,1,1,'h204,'hBEEF, 0,0,     0,1,0, 0,2,'h100,0, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,1, 1,1,'h204,'hBEEF, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,1, 1,1,'h204,'hBEEF, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,1, 1,1,'h204,'hBEEF, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     1,'h12345678, 0,0,1, 1,1,'h204,'hBEEF, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 1,1,'h204,'hBEEF, 0,'h00500093, 1,0);
      // fetch whose completion cycle accepts a new load
      add(1,'h300, 0,0,0,0,0,     0,0,          1,0,0, 1,1,'h204,'hBEEF, 0,'h00500093, 0,0);
      add(0,0,     0,0,0,0,0,     1,'hCAFEF00D, 0,0,1, 0,2,'h300,0, 0,'h00500093, 0,0);
      add(0,0,     1,0,4,'h400,'h55, 0,0,       0,1,0, 0,2,'h300,0, 1,'hCAFEF00D, 0,0);
      add(0,0,     0,0,0,0,0,     1,'hA5,       0,0,1, 0,4,'h400,'h55, 0,'hCAFEF00D, 0,0);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,4,'h400,'h55, 0,'hCAFEF00D, 1,'hA5);
      add(0,0,     0,0,0,0,0,     0,0,          0,0,0, 0,4,'h400,'h55, 0,'hCAFEF00D, 0,'hA5);

      // reset state, with both requests raised to show ready stays low
      drive('0);
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      @(negedge clk);
      check("reset_state", sample(), '0);
      #1;
      drive('0);
      rst = 1'b0;

      for (int r = 0; r < tbl.size(); r++) begin
         @(posedge clk);
         #1;
         drive(tbl[r].stim);
         @(negedge clk);
         check($sformatf("row%0d", r), sample(), tbl[r].exp);
      end

      // async reset in the middle of an unacked load
      @(posedge clk);
      #1;
      drive('0);
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h500;
      bus.d_size = 3'b010;
      @(negedge clk);
      check("rst_seq_grant", {bus.if_ready, bus.d_ready}, 2'b01);
      @(posedge clk);
      #1;
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      @(negedge clk);
      check("rst_seq_issue", {bus.m_req, bus.busy, bus.if_ready, bus.d_ready}, 4'b1100);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_ctrl", {bus.m_req, bus.busy, bus.if_ready, bus.d_ready,
                               bus.if_rvalid, bus.d_rvalid}, 6'b0);
      check("rst_async_data", {bus.m_addr, bus.if_rdata, bus.d_rdata}, '0);
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h77;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;

      // both requesters held, ack every ISSUE cycle: D, IF, D, IF
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("contend%0d", k),
               {bus.if_ready, bus.d_ready, bus.if_rvalid, bus.d_rvalid}, cont_exp[k]);
      end

      // load that memory never acknowledges
      @(posedge clk);
      #1;
      drive('0);
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h600;
      bus.d_size = 3'b010;
      @(negedge clk);
      check("stall_grant", {bus.if_ready, bus.d_ready}, 2'b01);
      @(posedge clk);
      #1;
      bus.d_req = 1'b0;
      cnt  = 0;
      stop = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (!stop) begin
            @(negedge clk);
            if (bus.m_req) cnt++;
            else stop = 1'b1;
         end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      check("timeout_len", cnt, 4);
      check("timeout_resp", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {2'b11, 32'h0});
`else
      check("stall_len", cnt, 20);
      check("stall_resp", {bus.m_req, bus.d_rvalid, bus.d_err, bus.d_rdata}, {3'b100, 32'h77});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
